// File: rtl/spindash_pkg.sv
// Shared types and constants for the YM write scheduler.
package spindash_pkg;

  // Default busy windows, in cen ticks
  localparam int YM_ADDR_GAP       = 17;
  localparam int YM_DATA_GAP_LONG  = 83;
  localparam int YM_DATA_GAP_SHORT = 47;

  // Registers at or above this number take the short data gap
  localparam logic [7:0] YM_LONG_GAP_LIMIT = 8'hA0;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } ym_state_e;

  typedef struct packed {
    logic [5:0] cs;
    logic [1:0] addr;
    logic [7:0] din;
  } ym_cmd_t;

  // Largest of the three gaps, used to size the busy counters
  function automatic int gap_max(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/ym_cmd_fifo.sv
// Command queue with first-word-fall-through head; depth is a power of two.
module ym_cmd_fifo
  import spindash_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  ym_cmd_t                  wdata,
  output ym_cmd_t                  head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  ym_cmd_t       mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];
  assign level   = count;

  // Pointers and occupancy; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents need no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ym_write_sched.sv
// Replays queued host writes onto the shared YM bus, honouring each chip's busy window.
module ym_write_sched
  import spindash_pkg::*;
#(
  parameter int YM_COUNT       = 9,
  parameter int FIFO_DEPTH     = 16,
  parameter int ADDR_GAP       = YM_ADDR_GAP,
  parameter int DATA_GAP_LONG  = YM_DATA_GAP_LONG,
  parameter int DATA_GAP_SHORT = YM_DATA_GAP_SHORT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cen,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [5:0]                    in_cs,
  input  logic [1:0]                    in_addr,
  input  logic [7:0]                    in_din,
  output logic [5:0]                    cs,
  output logic [1:0]                    addr,
  output logic [7:0]                    din,
  output logic                          wr_n,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          drop,
  output logic                          idle
);

  localparam int MAX_GAP = gap_max(ADDR_GAP, DATA_GAP_LONG, DATA_GAP_SHORT);
  localparam int BW      = $clog2(MAX_GAP + 1);

  ym_state_e     state_q;
  ym_state_e     state_d;
  ym_cmd_t       head;
  ym_cmd_t       push_cmd;
  logic          full;
  logic          empty;
  logic          pop;
  logic          load_bus;
  logic          strobe_done;
  logic          head_valid;
  logic          head_busy;
  logic          any_busy;
  logic [5:0]    cs_q;
  logic [1:0]    addr_q;
  logic [7:0]    din_q;
  logic [7:0]    cur_reg;
  logic [BW-1:0] gap_val;
  logic [BW-1:0] busy [YM_COUNT];
  logic [7:0]    regl [YM_COUNT][2];

  assign push_cmd   = {in_cs, in_addr, in_din};
  assign in_ready   = !full;
  assign head_valid = (head.cs != 6'd0) && (head.cs <= 6'(YM_COUNT));

  ym_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .pop   (pop),
    .wdata (push_cmd),
    .head  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // Per-chip lookups: head chip busy, latched register of the chip on the bus
  always_comb begin
    head_busy = 1'b0;
    any_busy  = 1'b0;
    cur_reg   = 8'h00;
    for (int i = 0; i < YM_COUNT; i++) begin
      if (head.cs == 6'(i + 1)) head_busy = (busy[i] != '0);
      if (cs_q == 6'(i + 1))    cur_reg   = regl[i][addr_q[1]];
      if (busy[i] != '0)        any_busy  = 1'b1;
    end
  end

  assign gap_val = !addr_q[0]                    ? BW'(ADDR_GAP)      :
                   (cur_reg < YM_LONG_GAP_LIMIT) ? BW'(DATA_GAP_LONG) :
                                                   BW'(DATA_GAP_SHORT);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state, queue pop and discard pulse
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    load_bus    = 1'b0;
    drop        = 1'b0;
    strobe_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          if (!head_valid) begin
            pop  = 1'b1;
            drop = 1'b1;
          end else if (!head_busy) begin
            pop      = 1'b1;
            load_bus = 1'b1;
            state_d  = SETUP;
          end
        end
      end
      SETUP:   state_d = STROBE;
      STROBE: begin
        if (cen) begin
          strobe_done = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus registers: loaded on issue, chip select released when HOLD ends
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_q   <= 6'd0;
      addr_q <= 2'd0;
      din_q  <= 8'h00;
    end else if (load_bus) begin
      cs_q   <= head.cs;
      addr_q <= head.addr;
      din_q  <= head.din;
    end else if (state_q == HOLD) begin
      cs_q   <= 6'd0;
    end
  end

  // Busy countdown per chip; a fresh load on strobe exit wins over the cen decrement
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < YM_COUNT; i++) busy[i] <= '0;
    end else begin
      for (int i = 0; i < YM_COUNT; i++) begin
        if (strobe_done && (cs_q == 6'(i + 1)))
          busy[i] <= gap_val;
        else if (cen && (busy[i] != '0))
          busy[i] <= busy[i] - 1'b1;
      end
    end
  end

  // Latched register number per chip and port, captured on address-write exit
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < YM_COUNT; i++) begin
        regl[i][0] <= 8'h00;
        regl[i][1] <= 8'h00;
      end
    end else begin
      for (int i = 0; i < YM_COUNT; i++) begin
        if (strobe_done && !addr_q[0] && (cs_q == 6'(i + 1)))
          regl[i][addr_q[1]] <= din_q;
      end
    end
  end

  assign cs   = cs_q;
  assign addr = addr_q;
  assign din  = din_q;
  assign wr_n = (state_q != STROBE);
  assign idle = empty && (state_q == IDLE) && !any_busy;

endmodule

// File: tb/tb_ym_write_sched.sv
// Directed bench for ym_write_sched: latency, gap selection, ordering, overflow, discard, reset.
module tb_ym_write_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cen = 1'b0;
  logic       in_valid = 1'b0;
  logic [5:0] in_cs = 6'd0;
  logic [1:0] in_addr = 2'd0;
  logic [7:0] in_din = 8'h00;
  logic       in_ready;
  logic [5:0] cs;
  logic [1:0] addr;
  logic [7:0] din;
  logic       wr_n;
  logic [4:0] level;
  logic       drop;
  logic       idle;

  int checks = 0;
  int failures = 0;

  ym_write_sched dut (
    .clk      (clk),
    .rst      (rst),
    .cen      (cen),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_cs    (in_cs),
    .in_addr  (in_addr),
    .in_din   (in_din),
    .cs       (cs),
    .addr     (addr),
    .din      (din),
    .wr_n     (wr_n),
    .level    (level),
    .drop     (drop),
    .idle     (idle)
  );

  always #5 clk = ~clk;

  // cen: one cycle in six, changed on the falling edge
  int cdiv = 0;
  always @(negedge clk) begin
    cdiv = (cdiv == 5) ? 0 : cdiv + 1;
    cen  = (cdiv == 0);
  end

  // Bus monitor: logs each strobe (chip, data, cen count before the fall, cen count
  // including the exit cycle, clock cycle of the fall) and counts drop pulses
  int   cyc = 0;
  int   cticks = 0;
  int   n_ev = 0;
  int   drops = 0;
  logic prev_wr_n = 1'b1;
  int   ev_cs   [128];
  int   ev_din  [128];
  int   ev_fall [128];
  int   ev_exit [128];
  int   ev_cyc  [128];

  always @(posedge clk) begin
    if (wr_n === 1'b0) begin
      if (prev_wr_n && n_ev < 128) begin
        ev_cs[n_ev]   = int'(cs);
        ev_din[n_ev]  = int'(din);
        ev_fall[n_ev] = cticks;
        ev_cyc[n_ev]  = cyc;
        n_ev++;
      end
      if (cen && n_ev > 0) ev_exit[n_ev-1] = cticks + 1;
    end
    if (drop === 1'b1) drops++;
    if (cen) cticks++;
    prev_wr_n = (wr_n !== 1'b0);
    cyc++;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic push(input int c, input int a, input int d);
    @(negedge clk);
    in_valid = 1'b1;
    in_cs    = 6'(c);
    in_addr  = 2'(a);
    in_din   = 8'(d);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int maxc);
    int k;
    k = 0;
    while (idle !== 1'b1 && k < maxc) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_idle_reached"}, int'(idle === 1'b1), 1);
  endtask

  initial begin
    int b;
    int dr;
    int k;

    // Reset held with a command presented
    rst = 1'b1; in_valid = 1'b1; in_cs = 6'd3; in_addr = 2'd0; in_din = 8'h28;
    repeat (8) @(negedge clk);
    chk("rst_cs", int'(cs), 0);
    chk("rst_addr", int'(addr), 0);
    chk("rst_din", int'(din), 0);
    chk("rst_wr_n", int'(wr_n), 1);
    chk("rst_drop", int'(drop), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_idle", int'(idle), 1);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_level", int'(level), 0);

    // Single address write to chip 3: latency, then address gap to a second write
    b = n_ev;
    push(3, 0, 8'h28);
    chk("lat_queued_level", int'(level), 1);
    chk("lat_queued_cs", int'(cs), 0);
    @(negedge clk);
    chk("lat_setup_cs", int'(cs), 3);
    chk("lat_setup_addr", int'(addr), 0);
    chk("lat_setup_din", int'(din), 8'h28);
    chk("lat_setup_wr_n", int'(wr_n), 1);
    chk("lat_setup_idle", int'(idle), 0);
    @(negedge clk);
    chk("lat_strobe_wr_n", int'(wr_n), 0);
    push(3, 1, 8'h55);
    wait_idle("addr_gap", 1000);
    chk("addr_gap_events", n_ev - b, 2);
    chk("addr_gap_cs", ev_cs[b+1], 3);
    chk_range("addr_gap_ticks", ev_fall[b+1] - ev_exit[b], 17, 18);

    // Long data gap: register 0x30 latched on chip 1
    b = n_ev;
    push(1, 0, 8'h30);
    push(1, 1, 8'h11);
    push(1, 0, 8'h31);
    wait_idle("long_gap", 2000);
    chk("long_gap_events", n_ev - b, 3);
    chk_range("long_gap_addr_ticks", ev_fall[b+1] - ev_exit[b], 17, 18);
    chk_range("long_gap_data_ticks", ev_fall[b+2] - ev_exit[b+1], 83, 84);

    // Short data gap: register 0xA4 latched on chip 1
    b = n_ev;
    push(1, 0, 8'hA4);
    push(1, 1, 8'h22);
    push(1, 0, 8'hA5);
    wait_idle("short_gap", 2000);
    chk("short_gap_events", n_ev - b, 3);
    chk_range("short_gap_data_ticks", ev_fall[b+2] - ev_exit[b+1], 47, 48);

    // Head-of-line: chip 2 waits behind chip 1's stalled data write
    b = n_ev;
    push(1, 0, 8'h40);
    push(1, 1, 8'h12);
    push(2, 0, 8'h2B);
    wait_idle("hol", 2000);
    chk("hol_events", n_ev - b, 3);
    chk("hol_cs0", ev_cs[b], 1);
    chk("hol_cs1", ev_cs[b+1], 1);
    chk("hol_cs2", ev_cs[b+2], 2);
    chk_range("hol_chip1_ticks", ev_fall[b+1] - ev_exit[b], 17, 18);
    chk_range("hol_chip2_after_chip1", ev_fall[b+2] - ev_exit[b+1], 0, 1);

    // Two idle chips back to back: strobe length 1..6 plus HOLD, IDLE, SETUP
    b = n_ev;
    push(2, 0, 8'h22);
    push(5, 0, 8'h27);
    wait_idle("b2b", 1000);
    chk("b2b_events", n_ev - b, 2);
    chk("b2b_cs0", ev_cs[b], 2);
    chk("b2b_cs1", ev_cs[b+1], 5);
    chk_range("b2b_spacing_clk", ev_cyc[b+1] - ev_cyc[b], 4, 9);

    // Overflow: chip 4 busy, sixteen queued, seventeenth held off
    b = n_ev;
    push(4, 0, 8'h00);
    repeat (10) @(negedge clk);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_cs    = 6'd4;
      in_addr  = 2'd0;
      in_din   = 8'(i);
    end
    @(negedge clk);
    in_din = 8'hEE;
    chk("ovf_full_level", int'(level), 16);
    chk("ovf_full_in_ready", int'(in_ready), 0);
    repeat (3) @(negedge clk);
    chk("ovf_hold_level", int'(level), 16);
    chk("ovf_hold_in_ready", int'(in_ready), 0);
    in_valid = 1'b0;
    wait_idle("ovf", 4000);
    chk("ovf_events", n_ev - b, 17);
    chk("ovf_last_cs", ev_cs[b+16], 4);
    chk("ovf_last_din", ev_din[b+16], 16);

    // Invalid chip numbers 0 and 10 back to back
    b  = n_ev;
    dr = drops;
    @(negedge clk);
    in_valid = 1'b1; in_cs = 6'd0; in_addr = 2'd0; in_din = 8'h99;
    @(negedge clk);
    in_cs = 6'd10;
    chk("drop_first", int'(drop), 1);
    chk("drop_first_level", int'(level), 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("drop_second", int'(drop), 1);
    chk("drop_pushpop_level", int'(level), 1);
    @(negedge clk);
    chk("drop_done", int'(drop), 0);
    chk("drop_done_level", int'(level), 0);
    repeat (10) @(negedge clk);
    chk("drop_count", drops - dr, 2);
    chk("drop_no_strobe", n_ev - b, 0);
    chk("drop_idle", int'(idle), 1);

    // Reset in the middle of a strobe
    b = n_ev;
    push(6, 0, 8'h2A);
    push(6, 1, 8'h33);
    k = 0;
    while (wr_n !== 1'b0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("rstmid_in_strobe", int'(wr_n), 0);
    chk("rstmid_level_before", int'(level), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_wr_n", int'(wr_n), 1);
    chk("rstmid_level", int'(level), 0);
    chk("rstmid_cs", int'(cs), 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("rstmid_idle", int'(idle), 1);
    chk("rstmid_no_more_strobes", n_ev - b, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
